// File: rtl/batch_mem_scheduler_pkg.sv
// Shared types and sizing helpers for the batch filter memory scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package batch_mem_scheduler_pkg;

    // How far the sample pipeline has filled: number of complete segments seen, saturating.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        RUN   = 2'd3
    } fill_t;

    // Default sizing of the batch filter.
    localparam int DEFAULT_DEPTH = 220;
    localparam int DEFAULT_N     = 3;
    localparam int DEFAULT_OSR   = 1;

    // Entries per segment: ceil(depth / osr).
    function automatic int calcDsd(input int depth, input int osr);
        return (depth + osr - 1) / osr;
    endfunction

    localparam int DEFAULT_DSD = calcDsd(DEFAULT_DEPTH, DEFAULT_OSR);

    // Sample RAM holds 4 segments, result RAMs hold 2 banks.
    localparam int DEFAULT_SAMPLE_AW = $clog2(4 * DEFAULT_DSD);
    localparam int DEFAULT_RES_AW    = $clog2(2 * DEFAULT_DSD);

endpackage

// File: rtl/batch_mem_scheduler_seg_counter.sv
// Enable-gated modulo counter with wrap pulse; optional saturation at maxVal.
// Latency: count updates on the clock edge after en; wrap is combinational from en and count.
// Backpressure: en low holds the count and suppresses wrap.
module seg_counter #(
    parameter int width    = 2,
    parameter int maxVal   = 3,
    parameter bit saturate = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [width-1:0] count,
    output logic             wrap
);

    logic atMax;

    assign atMax = (count == width'(maxVal));
    assign wrap  = en && atMax;

    // Step on en; at the top either return to zero or stick (saturating use).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            if (atMax) begin
                count <= saturate ? count : '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/batch_mem_scheduler.sv
// Sample/result RAM address sequencer for the batch filter: circular sample buffer, three read streams, result ping-pong.
// Latency: every output is registered, one cycle after the en cycle that issued the slot.
// Backpressure: en low stalls all state; write enables and batchStart drop, addresses and valids hold.
module batch_mem_scheduler
    import batch_mem_scheduler_pkg::*;
#(
    parameter  int depth = DEFAULT_DEPTH,
    parameter  int N     = DEFAULT_N,
    parameter  int OSR   = DEFAULT_OSR,
    localparam int DSD   = calcDsd(depth, OSR),
    localparam int CW    = (DSD > 1) ? $clog2(DSD) : 1,
    localparam int SAW   = $clog2(4 * DSD),
    localparam int RAW   = $clog2(2 * DSD)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic           sampleWrite,
    output logic [SAW-1:0] sampleAddrIn,
    output logic [SAW-1:0] sampleAddrOut1,
    output logic [SAW-1:0] sampleAddrOut2,
    output logic [SAW-1:0] sampleAddrOut3,
    output logic           resWriteF,
    output logic           resWriteB,
    output logic [RAW-1:0] resAddrInF,
    output logic [RAW-1:0] resAddrInB,
    output logic [RAW-1:0] resAddrOutF,
    output logic [RAW-1:0] resAddrOutB,
    output logic           batchStart,
    output logic           lookValid,
    output logic           calcValid,
    output logic           outValid
);

    // Sizing sanity: each sample carries at least one control signal, and OSR must divide something.
    if (N < 1 || OSR < 1) begin : gBadParams
        $error("batch_mem_scheduler: N and OSR must be >= 1");
    end

    logic [CW-1:0] cnt;
    logic [1:0]    wseg;
    logic [1:0]    fillCount;
    logic          bank;
    logic          cntWrap;
    logic          unusedSegWrap;
    logic          unusedFillWrap;
    fill_t         fill;

    // Slot within the segment.
    seg_counter #(.width(CW), .maxVal(DSD - 1), .saturate(1'b0)) uCnt (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .count (cnt),
        .wrap  (cntWrap)
    );

    // Sample RAM write segment, advances once per completed segment.
    seg_counter #(.width(2), .maxVal(3), .saturate(1'b0)) uSeg (
        .clk   (clk),
        .rst   (rst),
        .en    (cntWrap),
        .count (wseg),
        .wrap  (unusedSegWrap)
    );

    // Fill tracker: counts completed segments and parks at RUN.
    seg_counter #(.width(2), .maxVal(3), .saturate(1'b1)) uFill (
        .clk   (clk),
        .rst   (rst),
        .en    (cntWrap),
        .count (fillCount),
        .wrap  (unusedFillWrap)
    );

    assign fill = fill_t'(fillCount);

    // Bank toggles on every segment wrap and both start at zero, so it is the segment LSB.
    assign bank = wseg[0];

    // Base address of a sample segment.
    function automatic logic [SAW-1:0] segBase(input logic [1:0] seg);
        return SAW'(seg) * SAW'(DSD);
    endfunction

    logic [1:0]     segM1;
    logic [1:0]     segM2;
    logic [SAW-1:0] cntS;
    logic [SAW-1:0] revS;
    logic [RAW-1:0] cntR;
    logic [RAW-1:0] revR;
    logic [RAW-1:0] resBase;
    logic [RAW-1:0] resOtherBase;
    logic           calcNow;

    // Read segments trail the write segment with 2-bit wrap, so segment 0 aliases back to 3 and 2.
    assign segM1        = wseg - 2'd1;
    assign segM2        = wseg - 2'd2;
    assign cntS         = SAW'(cnt);
    assign revS         = SAW'(DSD - 1) - cntS;
    assign cntR         = RAW'(cnt);
    assign revR         = RAW'(DSD - 1) - cntR;
    assign resBase      = bank ? RAW'(DSD) : '0;
    assign resOtherBase = bank ? '0 : RAW'(DSD);
    assign calcNow      = (fill == TWO) || (fill == RUN);

    // Register the decode of the current slot when en issues it; hold addresses and valids on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sampleWrite    <= 1'b0;
            sampleAddrIn   <= '0;
            sampleAddrOut1 <= '0;
            sampleAddrOut2 <= '0;
            sampleAddrOut3 <= '0;
            resWriteF      <= 1'b0;
            resWriteB      <= 1'b0;
            resAddrInF     <= '0;
            resAddrInB     <= '0;
            resAddrOutF    <= '0;
            resAddrOutB    <= '0;
            batchStart     <= 1'b0;
            lookValid      <= 1'b0;
            calcValid      <= 1'b0;
            outValid       <= 1'b0;
        end else if (en) begin
            sampleWrite    <= 1'b1;
            sampleAddrIn   <= segBase(wseg) + cntS;
            sampleAddrOut1 <= segBase(segM1) + revS;
            sampleAddrOut2 <= segBase(segM2) + revS;
            sampleAddrOut3 <= segBase(segM2) + cntS;
            resWriteF      <= calcNow;
            resWriteB      <= calcNow;
            resAddrInF     <= resBase + cntR;
            resAddrInB     <= resBase + revR;
            resAddrOutF    <= resOtherBase + cntR;
            resAddrOutB    <= resOtherBase + cntR;
            batchStart     <= (cnt == '0);
            lookValid      <= (fill != EMPTY);
            calcValid      <= calcNow;
            outValid       <= (fill == RUN);
        end else begin
            sampleWrite    <= 1'b0;
            resWriteF      <= 1'b0;
            resWriteB      <= 1'b0;
            batchStart     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_batch_mem_scheduler.sv
// Randomized scoreboard bench for batch_mem_scheduler against a slot-count reference model.
// Latency: expectations are pushed at the driving negedge and checked 1 time unit after the next posedge.
// Backpressure: en is randomly deasserted; the model holds addresses and drops strobes on stalls.
module tb_batch_mem_scheduler;

    localparam int DSD = 220;
    localparam int SAW = 10;
    localparam int RAW = 9;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en  = 1'b0;
    logic           sampleWrite;
    logic [SAW-1:0] sampleAddrIn;
    logic [SAW-1:0] sampleAddrOut1;
    logic [SAW-1:0] sampleAddrOut2;
    logic [SAW-1:0] sampleAddrOut3;
    logic           resWriteF;
    logic           resWriteB;
    logic [RAW-1:0] resAddrInF;
    logic [RAW-1:0] resAddrInB;
    logic [RAW-1:0] resAddrOutF;
    logic [RAW-1:0] resAddrOutB;
    logic           batchStart;
    logic           lookValid;
    logic           calcValid;
    logic           outValid;

    batch_mem_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .sampleWrite    (sampleWrite),
        .sampleAddrIn   (sampleAddrIn),
        .sampleAddrOut1 (sampleAddrOut1),
        .sampleAddrOut2 (sampleAddrOut2),
        .sampleAddrOut3 (sampleAddrOut3),
        .resWriteF      (resWriteF),
        .resWriteB      (resWriteB),
        .resAddrInF     (resAddrInF),
        .resAddrInB     (resAddrInB),
        .resAddrOutF    (resAddrOutF),
        .resAddrOutB    (resAddrOutB),
        .batchStart     (batchStart),
        .lookValid      (lookValid),
        .calcValid      (calcValid),
        .outValid       (outValid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sampleWrite;
        int addrIn;
        int out1;
        int out2;
        int out3;
        int resWF;
        int resWB;
        int resInF;
        int resInB;
        int resOutF;
        int resOutB;
        int batchStart;
        int look;
        int calc;
        int outV;
    } exp_t;

    exp_t expQ[$];
    exp_t cur;
    int   slot;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compareAll(input exp_t e);
        check("sampleWrite", 32'(sampleWrite), e.sampleWrite);
        check("sampleAddrIn", 32'(sampleAddrIn), e.addrIn);
        check("sampleAddrOut1", 32'(sampleAddrOut1), e.out1);
        check("sampleAddrOut2", 32'(sampleAddrOut2), e.out2);
        check("sampleAddrOut3", 32'(sampleAddrOut3), e.out3);
        check("resWriteF", 32'(resWriteF), e.resWF);
        check("resWriteB", 32'(resWriteB), e.resWB);
        check("resAddrInF", 32'(resAddrInF), e.resInF);
        check("resAddrInB", 32'(resAddrInB), e.resInB);
        check("resAddrOutF", 32'(resAddrOutF), e.resOutF);
        check("resAddrOutB", 32'(resAddrOutB), e.resOutB);
        check("batchStart", 32'(batchStart), e.batchStart);
        check("lookValid", 32'(lookValid), e.look);
        check("calcValid", 32'(calcValid), e.calc);
        check("outValid", 32'(outValid), e.outV);
    endtask

    function automatic exp_t zeroExp();
        exp_t z;
        z = '{default: 0};
        return z;
    endfunction

    // Reference: everything follows from how many samples have been accepted since reset.
    function automatic exp_t slotExp(input int s);
        exp_t e;
        int c;
        int batches;
        int seg;
        int bnk;
        c       = s % DSD;
        batches = s / DSD;
        seg     = batches % 4;
        bnk     = batches % 2;
        e.sampleWrite = 1;
        e.addrIn      = seg * DSD + c;
        e.out1        = ((seg + 3) % 4) * DSD + (DSD - 1 - c);
        e.out2        = ((seg + 2) % 4) * DSD + (DSD - 1 - c);
        e.out3        = ((seg + 2) % 4) * DSD + c;
        e.look        = (batches >= 1) ? 1 : 0;
        e.calc        = (batches >= 2) ? 1 : 0;
        e.outV        = (batches >= 3) ? 1 : 0;
        e.resWF       = e.calc;
        e.resWB       = e.calc;
        e.resInF      = bnk * DSD + c;
        e.resInB      = bnk * DSD + (DSD - 1 - c);
        e.resOutF     = (1 - bnk) * DSD + c;
        e.resOutB     = (1 - bnk) * DSD + c;
        e.batchStart  = (c == 0) ? 1 : 0;
        return e;
    endfunction

    // Drive one cycle at the negedge and queue what the DUT must show after the next posedge.
    task automatic stepCycle(input logic r, input logic e);
        @(negedge clk);
        rst = r;
        en  = e;
        if (r) begin
            slot = 0;
            cur  = zeroExp();
        end else if (e) begin
            cur  = slotExp(slot);
            slot = slot + 1;
        end else begin
            cur.sampleWrite = 0;
            cur.resWF       = 0;
            cur.resWB       = 0;
            cur.batchStart  = 0;
        end
        expQ.push_back(cur);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                compareAll(e);
            end
        end
    end

    initial begin
        int guard;
        slot = 0;
        cur  = zeroExp();

        // Held in reset, then idle with en low.
        repeat (3) stepCycle(1'b1, 1'b0);
        repeat (10) stepCycle(1'b0, 1'b0);

        // First batch, then three more filling the pipeline, then past the segment 3 -> 0 wrap.
        repeat (220) stepCycle(1'b0, 1'b1);
        repeat (660) stepCycle(1'b0, 1'b1);
        repeat (5) stepCycle(1'b0, 1'b1);

        // Alternating stall pattern.
        for (int i = 0; i < 100; i++) stepCycle(1'b0, (i % 2) == 0);

        // Random stalls.
        for (int i = 0; i < 400; i++) stepCycle(1'b0, 1'($urandom_range(0, 3) != 0));

        // Run to slot 100 of segment 2, then assert reset between clock edges.
        guard = 0;
        while ((slot % (4 * DSD)) != (2 * DSD + 100) && guard < 2000) begin
            stepCycle(1'b0, 1'b1);
            guard++;
        end
        check("reachSeg2Cnt100", 32'(slot % (4 * DSD)), 32'(2 * DSD + 100));
        @(posedge clk);
        #3;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        compareAll(zeroExp());

        // Restart from empty.
        repeat (3) stepCycle(1'b1, 1'b0);
        repeat (4) stepCycle(1'b0, 1'b0);
        repeat (250) stepCycle(1'b0, 1'b1);
        for (int i = 0; i < 200; i++) stepCycle(1'b0, 1'($urandom_range(0, 1)));

        // Let the monitor drain the scoreboard.
        repeat (3) @(posedge clk);
        #2;
        check("scoreboardDrained", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
